// File: rtl/text_pkg.sv
// ============================================================================
// Module   : text_pkg
// Brief    : Shared types, the default fill character and width helpers for
//            the text line streamer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package text_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_PAD_CHAR = 8'h20;

  // Counter wide enough to hold the value n itself, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int slot_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/char_unpack.sv
// ============================================================================
// Module   : char_unpack
// Brief    : Selects one character from a packed ROM word, char 0 in the MSBs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module char_unpack #(
  parameter int CHAR_W         = 8,
  parameter int CHARS_PER_WORD = 2,
  parameter int SLOT_W         = 1
) (
  input  logic [CHAR_W*CHARS_PER_WORD-1:0] word_i,
  input  logic [SLOT_W-1:0]                slot_i,
  output logic [CHAR_W-1:0]                char_o
);

  logic [CHAR_W-1:0] chars [CHARS_PER_WORD];

  for (genvar gi = 0; gi < CHARS_PER_WORD; gi++) begin : g_split
    assign chars[gi] = word_i[(CHARS_PER_WORD-1-gi)*CHAR_W +: CHAR_W];
  end

  always_comb begin
    char_o = '0;
    for (int k = 0; k < CHARS_PER_WORD; k++) begin
      if (slot_i == SLOT_W'(k)) char_o = chars[k];
    end
  end

endmodule

`default_nettype wire

// File: rtl/text_line_streamer.sv
// ============================================================================
// Module   : text_line_streamer
// Brief    : Streams one fixed-length, pad-filled text line per request from a
//            line table and a packed character ROM, with valid/ready output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module text_line_streamer
  import text_pkg::*;
#(
  parameter int                ADDR_W         = 8,
  parameter int                LINE_IDX_W     = 8,
  parameter int                CHAR_W         = 8,
  parameter int                CHARS_PER_WORD = 2,
  parameter int                LINE_LEN       = 16,
  parameter logic [CHAR_W-1:0] PAD_CHAR       = CHAR_W'(DEFAULT_PAD_CHAR)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [LINE_IDX_W-1:0]            req_line,
  output logic [LINE_IDX_W-1:0]            map_line,
  input  logic [ADDR_W-1:0]                map_start,
  input  logic [ADDR_W-1:0]                map_end,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [CHAR_W*CHARS_PER_WORD-1:0] rom_data,
  output logic                             ch_valid,
  input  logic                             ch_ready,
  output logic [CHAR_W-1:0]                ch_data,
  output logic                             ch_last,
  output logic                             busy
);

  localparam int CNT_W  = cnt_width(LINE_LEN);
  localparam int SLOT_W = slot_width(CHARS_PER_WORD);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LINE_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHARS_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [LINE_IDX_W-1:0] map_line_q;
  logic [ADDR_W-1:0]   word_ptr_q;
  logic [ADDR_W-1:0]   end_ptr_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [CNT_W-1:0]    char_cnt_q;
  logic                empty_q;
  logic                exhausted_q;
  logic                ch_valid_q;
  logic [CHAR_W-1:0]   ch_data_q;
  logic                ch_last_q;

  logic                load_beat;
  logic                last_taken;
  logic [CHAR_W-1:0]   rom_char;
  logic [CHAR_W-1:0]   src_char;

  char_unpack #(
    .CHAR_W        (CHAR_W),
    .CHARS_PER_WORD(CHARS_PER_WORD),
    .SLOT_W        (SLOT_W)
  ) u_unpack (
    .word_i(rom_data),
    .slot_i(slot_q),
    .char_o(rom_char)
  );

  // char_cnt reaching LINE_LEN means every beat of the line has been loaded.
  assign load_beat  = (state_q == EMIT) && (!ch_valid_q || ch_ready)
                      && (char_cnt_q != CNT_W'(LINE_LEN));
  assign last_taken = (state_q == EMIT) && ch_valid_q && ch_ready && ch_last_q;
  assign src_char   = (empty_q || exhausted_q) ? PAD_CHAR : rom_char;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOAD;
      LOAD:    state_d = EMIT;
      EMIT:    if (last_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    map_line  = map_line_q;
    rom_addr  = word_ptr_q;
    ch_valid  = ch_valid_q;
    ch_data   = ch_data_q;
    ch_last   = ch_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_line_q  <= '0;
      word_ptr_q  <= '0;
      end_ptr_q   <= '0;
      slot_q      <= '0;
      char_cnt_q  <= '0;
      empty_q     <= 1'b0;
      exhausted_q <= 1'b0;
      ch_valid_q  <= 1'b0;
      ch_data_q   <= PAD_CHAR;
      ch_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) map_line_q <= req_line;
        end
        LOAD: begin
          word_ptr_q  <= map_start;
          end_ptr_q   <= map_end;
          slot_q      <= '0;
          char_cnt_q  <= '0;
          empty_q     <= (map_end < map_start);
          exhausted_q <= 1'b0;
        end
        EMIT: begin
          if (load_beat) begin
            ch_valid_q <= 1'b1;
            ch_data_q  <= src_char;
            ch_last_q  <= (char_cnt_q == LAST_CNT);
            char_cnt_q <= char_cnt_q + 1'b1;
            // Hold the pointer on the final beat so truncated lines never read past it.
            if ((char_cnt_q != LAST_CNT) && !empty_q && !exhausted_q) begin
              if (slot_q == LAST_SLOT) begin
                if (word_ptr_q == end_ptr_q) begin
                  exhausted_q <= 1'b1;
                end else begin
                  slot_q     <= '0;
                  word_ptr_q <= word_ptr_q + 1'b1;
                end
              end else begin
                slot_q <= slot_q + 1'b1;
              end
            end
          end else if (ch_valid_q && ch_ready) begin
            ch_valid_q <= 1'b0;
            ch_last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_line_streamer.sv
// ============================================================================
// Module   : tb_text_line_streamer
// Brief    : Scoreboard bench for text_line_streamer (default and 4-char/6-beat
//            configurations).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_text_line_streamer;

  localparam int LEN_A = 16;
  localparam int CPW_A = 2;
  localparam int LEN_B = 6;
  localparam int CPW_B = 4;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid_a, req_ready_a, ch_valid_a, ch_ready_a, ch_last_a, busy_a;
  logic [7:0]  req_line_a, map_line_a, map_start_a, map_end_a, rom_addr_a, ch_data_a;
  logic [15:0] rom_data_a;

  logic        req_valid_b, req_ready_b, ch_valid_b, ch_ready_b, ch_last_b, busy_b;
  logic [7:0]  req_line_b, map_line_b, map_start_b, map_end_b, rom_addr_b, ch_data_b;
  logic [31:0] rom_data_b;

  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];
  logic [7:0]  st_a [256];
  logic [7:0]  en_a [256];
  logic [7:0]  st_b [256];
  logic [7:0]  en_b [256];

  assign map_start_a = st_a[map_line_a];
  assign map_end_a   = en_a[map_line_a];
  assign rom_data_a  = rom_a[rom_addr_a][15:0];
  assign map_start_b = st_b[map_line_b];
  assign map_end_b   = en_b[map_line_b];
  assign rom_data_b  = rom_b[rom_addr_b];

  text_line_streamer u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_line(req_line_a),
    .map_line(map_line_a), .map_start(map_start_a), .map_end(map_end_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .ch_valid(ch_valid_a), .ch_ready(ch_ready_a), .ch_data(ch_data_a),
    .ch_last(ch_last_a), .busy(busy_a)
  );

  text_line_streamer #(.CHARS_PER_WORD(CPW_B), .LINE_LEN(LEN_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_line(req_line_b),
    .map_line(map_line_b), .map_start(map_start_b), .map_end(map_end_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .ch_valid(ch_valid_b), .ch_ready(ch_ready_b), .ch_data(ch_data_b),
    .ch_last(ch_last_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_char(input logic [31:0] w, input int cpw, input int slot);
    return w[(cpw-1-slot)*8 +: 8];
  endfunction

  beat_t sb_a[$];
  beat_t sb_b[$];

  task automatic push_a(input int line);
    int s, e, total;
    beat_t b;
    s = int'(st_a[line]);
    e = int'(en_a[line]);
    total = (e >= s) ? (e - s + 1) * CPW_A : 0;
    for (int k = 0; k < LEN_A; k++) begin
      b.ch   = (k < total) ? exp_char(rom_a[s + k / CPW_A], CPW_A, k % CPW_A) : 8'h20;
      b.last = (k == LEN_A - 1);
      sb_a.push_back(b);
    end
  endtask

  task automatic push_b(input int line);
    int s, e, total;
    beat_t b;
    s = int'(st_b[line]);
    e = int'(en_b[line]);
    total = (e >= s) ? (e - s + 1) * CPW_B : 0;
    for (int k = 0; k < LEN_B; k++) begin
      b.ch   = (k < total) ? exp_char(rom_b[s + k / CPW_B], CPW_B, k % CPW_B) : 8'h20;
      b.last = (k == LEN_B - 1);
      sb_b.push_back(b);
    end
  endtask

  // Monitors sample at negedge: valid&ready seen here transfers on the next posedge.
  logic       stall_a = 1'b0;
  logic [7:0] hold_d_a;
  logic       hold_l_a;
  int         beats_a = 0;
  int         max_addr_a = 0;
  beat_t      pop_a;

  always @(negedge clk) begin
    if (rst) begin
      sb_a.delete();
      stall_a = 1'b0;
    end else begin
      if (ch_valid_a) begin
        if (stall_a) begin
          check("a_hold_data", ch_data_a, hold_d_a);
          check("a_hold_last", ch_last_a, hold_l_a);
        end
        if (ch_ready_a) begin
          beats_a++;
          if (int'(rom_addr_a) > max_addr_a) max_addr_a = int'(rom_addr_a);
          if (sb_a.size() == 0) begin
            check("a_unexpected_beat", ch_valid_a, 1'b0);
          end else begin
            pop_a = sb_a.pop_front();
            check("a_data", ch_data_a, pop_a.ch);
            check("a_last", ch_last_a, pop_a.last);
          end
          stall_a = 1'b0;
        end else begin
          stall_a  = 1'b1;
          hold_d_a = ch_data_a;
          hold_l_a = ch_last_a;
        end
      end
      if (req_valid_a && req_ready_a) begin
        check("a_accept_drained", sb_a.size(), 0);
        push_a(int'(req_line_a));
        beats_a    = 0;
        max_addr_a = 0;
      end
    end
  end

  int    beats_b = 0;
  int    accepts_b = 0;
  beat_t pop_b;

  always @(negedge clk) begin
    if (rst) begin
      sb_b.delete();
    end else begin
      if (ch_valid_b && ch_ready_b) begin
        beats_b++;
        check("b_rom_addr", rom_addr_b, 8'hFF);
        if (sb_b.size() == 0) begin
          check("b_unexpected_beat", ch_valid_b, 1'b0);
        end else begin
          pop_b = sb_b.pop_front();
          check("b_data", ch_data_b, pop_b.ch);
          check("b_last", ch_last_b, pop_b.last);
        end
      end
      if (req_valid_b && req_ready_b) begin
        check("b_accept_drained", sb_b.size(), 0);
        push_b(int'(req_line_b));
        accepts_b++;
      end
    end
  end

  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  int         rdy_cyc  = 0;

  initial begin
    ch_ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_cyc++;
      ch_ready_a = rdy_mode ? rdy_pat[rdy_cyc % 4] : 1'b1;
    end
  end

  task automatic req_a(input logic [7:0] line);
    int n;
    n = 0;
    while (!req_ready_a && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("a_req_ready", req_ready_a, 1'b1);
    req_valid_a = 1'b1;
    req_line_a  = line;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("a_latency_n1", ch_valid_a, 1'b0);
    @(negedge clk);
    check("a_latency_n2", ch_valid_a, 1'b1);
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while ((busy_a || sb_a.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("a_busy_done", busy_a, 1'b0);
    check("a_sb_empty", sb_a.size(), 0);
    check("a_beat_count", beats_a, LEN_A);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = {16'h0, 8'(8'h41 + 2 * i), 8'(8'h42 + 2 * i)};
      rom_b[i] = 32'h30313233;
      st_a[i] = 8'h00; en_a[i] = 8'h00;
      st_b[i] = 8'h00; en_b[i] = 8'h00;
    end
    st_a[0] = 8'd0; en_a[0] = 8'd1;
    st_a[1] = 8'd5; en_a[1] = 8'd4;
    st_a[2] = 8'd0; en_a[2] = 8'd9;
    rom_b[255] = 32'h5758595A;
    st_b[0] = 8'hFF; en_b[0] = 8'hFF;

    rst = 1'b1;
    req_valid_a = 1'b0; req_line_a = 8'h00;
    req_valid_b = 1'b0; req_line_b = 8'h00;
    ch_ready_b  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ch_valid", ch_valid_a, 1'b0);
    check("rst_ch_data", ch_data_a, 8'h20);
    check("rst_ch_last", ch_last_a, 1'b0);
    check("rst_map_line", map_line_a, 8'h00);
    check("rst_rom_addr", rom_addr_a, 8'h00);
    check("rst_busy", busy_a, 1'b0);
    check("rst_req_ready", req_ready_a, 1'b1);
    check("rst_b_busy", busy_b, 1'b0);

    // Short line padded to full length.
    req_a(8'd0);
    wait_done_a();

    // Empty range.
    req_a(8'd1);
    wait_done_a();

    // Range longer than the line: truncated.
    req_a(8'd2);
    wait_done_a();
    check("a_trunc_max_addr", max_addr_a, 7);

    // Backpressure.
    rdy_mode = 1'b1;
    req_a(8'd0);
    wait_done_a();
    rdy_mode = 1'b0;

    // Reset mid-line after the third beat transfers.
    req_a(8'd0);
    n = 0;
    while (beats_a < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("a_reached_beat3", beats_a, 3);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("a_midrst_valid", ch_valid_a, 1'b0);
    check("a_midrst_ready", req_ready_a, 1'b1);
    check("a_midrst_busy", busy_a, 1'b0);
    req_a(8'd0);
    wait_done_a();

    // Top-of-range line on the 4-char, 6-beat instance with req_valid held high.
    @(posedge clk);
    #1;
    req_valid_b = 1'b1;
    req_line_b  = 8'd0;
    n = 0;
    while (accepts_b < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 req_valid_b = 1'b0;
    n = 0;
    while ((busy_b || sb_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_accepts", accepts_b, 2);
    check("b_busy_done", busy_b, 1'b0);
    check("b_sb_empty", sb_b.size(), 0);
    check("b_beat_count", beats_b, 2 * LEN_B);
    check("b_final_rom_addr", rom_addr_b, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_line_streamer.md
Name: text_line_streamer

Overview:
- Streams one fixed-length text line as a sequence of characters, one per handshake beat.
- For each requested line index it:
  - looks up the line's word-address range in an external line table;
  - reads multi-character words from an external character ROM;
  - unpacks them most-significant character first;
  - pads with a fill character up to LINE_LEN.
- Sits between the line-table/character-ROM lookups and the display/serial output path.
- Generalises those lookups to parametrised widths and word packing, and adds flow control.

Parameters:
- ADDR_W, 8: ROM word-address width; line-table start/end width.
- LINE_IDX_W, 8: line index width.
- CHAR_W, 8: bits per character.
- CHARS_PER_WORD, 2: characters packed per ROM word (>=1).
- LINE_LEN, 16: characters emitted per line (>=1).
- PAD_CHAR, 8'h20: fill character (CHAR_W wide).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  line request valid
- req_ready  out  1  high only in IDLE
- req_line  in  LINE_IDX_W  requested line index
- map_line  out  LINE_IDX_W  registered index driven to the line table
- map_start  in  ADDR_W  first word address, combinational from map_line
- map_end  in  ADDR_W  last word address (inclusive)
- rom_addr  out  ADDR_W  word pointer to the character ROM
- rom_data  in  CHAR_W*CHARS_PER_WORD  combinational ROM word; char 0 in the MSBs
- ch_valid  out  1  output character valid
- ch_ready  in  1  downstream ready
- ch_data  out  CHAR_W  character
- ch_last  out  1  high with the LINE_LEN-th character
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge) values:
  - state=IDLE; ch_valid=0, ch_data=PAD_CHAR, ch_last=0; map_line=0, rom_addr=0; busy=0.
- Reset mid-line: the partial line is abandoned with no further beats. Takes precedence over every other event in the same cycle.
- Handshake on both interfaces: a transfer occurs when valid&ready at posedge.
  - ch_data/ch_last stay stable while ch_valid=1 and ch_ready=0.
  - ch_valid does not depend combinationally on ch_ready.
- State IDLE:
  - req_ready=1.
  - On req_valid: map_line<=req_line; go to LOAD.
- State LOAD (1 cycle):
  - Capture map_start/map_end into word_ptr/end_ptr.
  - Clear char_cnt, slot=0.
  - empty flag <= (map_end < map_start), unsigned compare.
  - Go to EMIT.
- rom_addr = word_ptr (registered).
- State EMIT: the output register loads when !ch_valid || ch_ready.
  - Character source: if empty=0 and the range is not exhausted, ch_data = rom_data slot `slot`; otherwise PAD_CHAR.
  - Slot advance: slot increments. On slot=CHARS_PER_WORD-1:
    - if word_ptr==end_ptr, mark the range exhausted (sticky);
    - else slot<=0 and word_ptr+1.
  - word_ptr never wraps past 2^ADDR_W-1: exhaustion is by equality, not overflow.
  - char_cnt increments per loaded character.
  - ch_last=1 when char_cnt==LINE_LEN-1.
  - Truncation: chars beyond LINE_LEN are never emitted.
  - After the ch_last beat is accepted (and no new beat is loaded): ch_valid<=0; go to IDLE.
- Latency and throughput:
  - req accepted at cycle N → first ch_valid at cycle N+2.
  - With ch_ready held high: one character per cycle; exactly LINE_LEN beats per request.
  - The next req is accepted the cycle after returning to IDLE.
- Line cost: every line costs exactly LINE_LEN beats regardless of range length.
- Empty line: all beats are PAD_CHAR.
- req_valid while busy is ignored; req_line is sampled only on accept.
- Widths:
  - char_cnt is $clog2(LINE_LEN+1) bits.
  - slot is $clog2(CHARS_PER_WORD), minimum 1 bit.

Decomposition:
- Package text_pkg holds:
  - state enum {IDLE, LOAD, EMIT};
  - default PAD_CHAR;
  - helper function for the counter width.
- Sub-module char_unpack: a parametrised mux that selects slot i of a CHARS_PER_WORD-character word, MSB-first. Purely combinational.
- FSM and counters stay in text_line_streamer.

Test Plan:
- Defaults; table line0 → start=0, end=1; ROM[0]=16'h4142, ROM[1]=16'h4344; ch_ready=1; req line 0
  → beats 'A','B','C','D', then 12×8'h20, with ch_last on beat 16; first ch_valid 2 cycles after accept.
- map_start=5, map_end=4 (empty line)
  → 16×8'h20; ch_last on the 16th.
- Range 0..9 (20 chars) with LINE_LEN=16
  → first 16 ROM chars only; returns to IDLE; rom_addr never exceeds 7.
- ch_ready toggled 1-0-0-1 on every beat
  → ch_data/ch_last held stable during stalls; no duplicated or lost characters; sequence identical to test 1.
- rst pulsed for 1 cycle after beat 3 of a line
  → next cycle ch_valid=0, req_ready=1, busy=0; a fresh request streams from its first character.
- map_start=map_end=8'hFF with CHARS_PER_WORD=4, LINE_LEN=6
  → 4 ROM chars then 2 pads; word_ptr stays 8'hFF (no wrap); req_valid held high while busy is not accepted early.
